// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the packed {HI,LO} result type.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W          = 5;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational {HI,LO} result for the latched op/operands; write_en is low
// for divide-by-zero so the caller leaves HI/LO untouched.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output hilo_t       result,
    output logic        write_en
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        ext_a = {32'b0, a};
        ext_b = {32'b0, b};
        if (op == OP_MULT) begin
            ext_a = {{32{a[31]}}, a};
            ext_b = {{32{b[31]}}, b};
        end
        prod = ext_a * ext_b;

        // Signed division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        neg_a = (op == OP_DIV) && a[31];
        neg_b = (op == OP_DIV) && b[31];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
        quo   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        rem   = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;

        result   = '0;
        write_en = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: begin
                result   = prod;
                write_en = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                if (b != 32'd0) begin
                    result.lo = (neg_a ^ neg_b) ? -quo : quo;
                    result.hi = neg_a ? -rem : rem;
                    write_en  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle MIPS-style multiply/divide unit holding HI/LO, the busy
// counter and the operand latches; arithmetic lives in mdu_calc.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] rdata
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [CNT_W-1:0] count_reg;
    logic [2:0]       op_reg;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic             accept;
    hilo_t            calc_result;
    logic             calc_write_en;

    assign busy   = (count_reg != '0);
    assign accept = start && !busy;
    assign rdata  = rd_hi ? hi_reg : lo_reg;

    mdu_calc u_calc (
        .op       (op_reg),
        .a        (a_reg),
        .b        (b_reg),
        .result   (calc_result),
        .write_en (calc_write_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg    <= '0;
            lo_reg    <= '0;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else if (accept) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    op_reg    <= op;
                    a_reg     <= a;
                    b_reg     <= b;
                    count_reg <= MUL_CNT;
                end
                OP_DIV, OP_DIVU: begin
                    op_reg    <= op;
                    a_reg     <= a;
                    b_reg     <= b;
                    count_reg <= DIV_CNT;
                end
                OP_MTHI: hi_reg <= a;
                OP_MTLO: lo_reg <= a;
                default: ;
            endcase
        end else if (busy) begin
            count_reg <= count_reg - 1'b1;
            // Result lands on the same edge that drops busy.
            if (count_reg == CNT_W'(1) && calc_write_en) begin
                hi_reg <= calc_result.hi;
                lo_reg <= calc_result.lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized ops
// compared against an arithmetic model of HI/LO.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic        busy;
    logic [31:0] rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .rd_hi (rd_hi),
        .busy  (busy),
        .rdata (rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [31:0] eh, input logic [31:0] el);
        rd_hi = 1'b1;
        #1;
        check({tag, "_hi"}, rdata, eh);
        rd_hi = 1'b0;
        #1;
        check({tag, "_lo"}, rdata, el);
    endtask

    function automatic void model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  inout logic [31:0] h, inout logic [31:0] l);
        int     sa;
        int     sb;
        longint p;
        sa = ma;
        sb = mb;
        case (mop)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                {h, l} = p;
            end
            3'd1: {h, l} = {32'b0, ma} * {32'b0, mb};
            3'd2: begin
                if (mb != 0) begin
                    if (ma == 32'h80000000 && mb == 32'hFFFFFFFF) begin
                        l = 32'h80000000;
                        h = 32'h0;
                    end else begin
                        l = sa / sb;
                        h = sa % sb;
                    end
                end
            end
            3'd3: begin
                if (mb != 0) begin
                    l = ma / mb;
                    h = ma % mb;
                end
            end
            3'd4: h = ma;
            3'd5: l = ma;
            default: ;
        endcase
    endfunction

    function automatic int cycles_for(input logic [2:0] mop);
        if (mop == 3'd0 || mop == 3'd1) return 5;
        if (mop == 3'd2 || mop == 3'd3) return 10;
        return 0;
    endfunction

    // Issue one op, optionally scrambling inputs and firing ignored starts while busy.
    task automatic do_op(input string tag, input logic [2:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input bit noisy);
        logic [31:0] ph;
        logic [31:0] pl;
        int          n;
        ph = m_hi;
        pl = m_lo;
        n  = 0;
        @(negedge clk);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (busy && n < 64) begin
            n++;
            if (n == 1) read_check({tag, "_during_busy"}, ph, pl);
            if (noisy) begin
                a     = $urandom;
                b     = $urandom;
                op    = 3'($urandom_range(0, 7));
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(cycles_for(t_op)));
        model(t_op, t_a, t_b, m_hi, m_lo);
        read_check({tag, "_result"}, m_hi, m_lo);
        $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", t_op, t_a, t_b, n, m_hi, m_lo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        rd_hi = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        read_check("reset", 32'd0, 32'd0);

        do_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        read_check("mult_const", 32'hFFFFFFFF, 32'hFFFFFFFA);
        do_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
        read_check("multu_const", 32'h00000001, 32'hFFFFFFFE);
        do_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        read_check("div_const", 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 1'b0);
        read_check("divu_zero_const", 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        read_check("div_ovf_const", 32'h00000000, 32'h80000000);
        do_op("mthi", OP_MTHI, 32'h12345678, 32'd0, 1'b0);
        read_check("mthi_const", 32'h12345678, 32'h80000000);
        do_op("bad_op6", 3'd6, 32'hAAAA5555, 32'd1, 1'b0);
        do_op("bad_op7", 3'd7, 32'h5555AAAA, 32'd1, 1'b0);

        // MTLO pulsed in busy cycle 2 of a MULT must be dropped.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = OP_MTLO; a = 32'hDEADBEEF;
        @(posedge clk); #1; start = 1'b0;
        n = 2;
        while (busy && n < 64) begin
            n++;
            @(posedge clk); #1;
        end
        check("mtlo_busy_cycles", 32'(n), 32'd5);
        m_hi = 32'd0; m_lo = 32'd12;
        read_check("mtlo_ignored", m_hi, m_lo);
        $display("mult 3*4 with mtlo during busy: hi=%h lo=%h", m_hi, m_lo);

        // A start held across the falling edge of busy is taken only one cycle later.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        op = OP_MTLO; a = 32'hCAFEF00D;
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(posedge clk); #1;
        end
        check("held_busy_cycles", 32'(n), 32'd5);
        read_check("held_at_fall", 32'd0, 32'd42);
        @(posedge clk); #1;
        start = 1'b0;
        m_hi = 32'd0; m_lo = 32'hCAFEF00D;
        read_check("held_after", m_hi, m_lo);
        $display("held mtlo after mult: hi=%h lo=%h", m_hi, m_lo);

        // Reset mid-operation aborts; the ignored DIV must not surface later.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        check("abort_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("abort_busy", 32'(busy), 32'd0);
        read_check("abort_cleared", m_hi, m_lo);
        repeat (12) @(posedge clk);
        #1;
        check("abort_busy_later", 32'(busy), 32'd0);
        read_check("abort_no_late_write", m_hi, m_lo);
        $display("reset during busy: hi=%h lo=%h", m_hi, m_lo);

        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 9));
                2: r_a = 32'h80000000;
                default: ;
            endcase
            do_op("rand", r_op, r_a, r_b, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MUL_CYCLES, default 5, busy duration of MULT/MULTU in cycles (range 1..31).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (range 1..31).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to execute op with operands a/b.
REQ-006 op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 a  input  32  operand 1, driven from register-file read port 1 (rs).
REQ-008 b  input  32  operand 2, driven from register-file read port 2 (rt).
REQ-009 rd_hi  input  1  read select: 1 = HI, 0 = LO (MFHI/MFLO).
REQ-010 busy  output  1  computation in progress; upstream stalls MDU instructions while high.
REQ-011 rdata  output  32  combinational HI or LO per rd_hi; feeds register-file write-data mux.

Function
REQ-012 Accepted start: start=1 and busy=0 at a rising edge; start while busy=1 is ignored, no state change.
REQ-013 Accepted MULT/MULTU/DIV/DIVU latches a and b, loads counter with MUL_CYCLES or DIV_CYCLES, and sets busy=1 from the next cycle.
REQ-014 busy stays high for exactly MUL_CYCLES or DIV_CYCLES cycles; HI/LO update on the same edge busy returns to 0.
REQ-015 Operations use latched operands only; a/b changes during busy have no effect.
REQ-016 MULT: {HI,LO} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-017 DIV: LO = signed quotient truncated toward zero, HI = remainder carrying the dividend's sign.
REQ-018 DIVU: LO = unsigned quotient, HI = unsigned remainder.
REQ-019 Divisor 0 (DIV or DIVU): busy still runs DIV_CYCLES; HI and LO remain unchanged.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no trap.
REQ-021 Accepted MTHI/MTLO writes a into HI/LO at that edge; busy stays 0; effect visible next cycle.
REQ-022 rdata is combinational from the HI/LO registers, reflecting state as of the last edge; reads during busy return pre-operation values.
REQ-023 Unlisted op encodings with start=1 are ignored.
REQ-024 A start accepted on the same edge busy falls is not possible; the first acceptable edge is one cycle after busy reads 0.

Reset
REQ-025 Synchronous reset: HI=0, LO=0, busy=0, counter=0, latched operands=0.
REQ-026 Reset during busy aborts the operation; HI/LO=0 next cycle, no late result write.
REQ-027 Reset has priority over start at the same edge.

Structure
REQ-028 Shared package mdu_pkg holds op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5) and default latency constants.
REQ-029 One sub-module, mdu_calc: combinational 64-bit {HI,LO} result from latched op and operands; mdu holds the counter, latches and HI/LO.

Verification
REQ-030 MULT a=0xFFFFFFFE, b=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-032 DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 -> HI/LO unchanged.
REQ-033 MTHI a=0x12345678, then rd_hi=1 next cycle -> rdata=0x12345678; MTLO during busy -> ignored.
REQ-034 Start MULT, second start DIV at busy cycle 2, reset at busy cycle 3 -> DIV ignored; busy=0, HI=LO=0 next cycle, no later update.
REQ-035 Change a/b every cycle during DIV busy -> result equals that of the operands latched at start.
